axi_lite_reg_test_master: RTL and testbench
===========================================

Name: axi_lite_reg_test_master

Overview:
- Synthesizable AXI4-Lite master that runs a self-checking register write/read-back sweep over a parametrised window of slave registers.
- Successor to the bench-only single-pattern register test: adds pattern modes, configurable register count and stride, response checking, error counting and a per-transaction watchdog.
- Sits between a control/status interface (or a top-level bring-up wrapper) and any AXI4-Lite slave peripheral, e.g. the TFT SPI display register bank, for on-hardware self-test.

Parameters:
- C_M_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_M_AXI_ADDR_WIDTH, 32, address bus width.
- C_BASE_ADDR, 32'h0, address of register 0.
- C_NUM_REGS, 4, registers swept, 1..256.
- C_ADDR_STRIDE, 4, byte offset between registers.
- C_TIMEOUT, 1024, maximum cycles spent waiting on any single handshake.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; accepted only when idle.
- mode  in  2  pattern select, sampled at start.
- seed  in  32  pattern seed, sampled at start.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at sweep end.
- pass  out  1  last sweep had zero errors and no timeout; held until next start.
- timeout  out  1  last sweep aborted by the watchdog.
- err_count  out  9  mismatches plus non-OKAY responses in the last sweep.
- first_err_index  out  8  register index of the first error; 0 if none.
- M_AXI_AWADDR/AWPROT/AWVALID  out  ADDR/3/1; M_AXI_AWREADY  in  1.
- M_AXI_WDATA/WSTRB/WVALID  out  32/4/1; M_AXI_WREADY  in  1.
- M_AXI_BRESP  in  2; M_AXI_BVALID  in  1; M_AXI_BREADY  out  1.
- M_AXI_ARADDR/ARPROT/ARVALID  out  ADDR/3/1; M_AXI_ARREADY  in  1.
- M_AXI_RDATA  in  32; M_AXI_RRESP  in  2; M_AXI_RVALID  in  1; M_AXI_RREADY  out  1.

Behaviour:
- Clocking and reset: one clock, ACLK; reset ARESETN is asynchronous and active-low.
- Reset values: all VALID/READY outputs 0; busy, done, pass, timeout 0; err_count 0; first_err_index 0; addresses and data 0; state IDLE.
- AWPROT = ARPROT = 3'b000; WSTRB = 4'hF.
- FSM states: IDLE, WRITE, WRESP, READ, RDATA, CHECK, NEXT, FIN.
- IDLE: on start, latch mode and seed; clear err_count, first_err_index, pass, timeout; set idx=0, busy=1; go to WRITE next cycle.
- WRITE: assert AWVALID and WVALID together. Drop each VALID independently on its own handshake; either order is legal. Once both handshakes are done, go to WRESP.
- WRESP: hold BREADY=1. On BVALID, if BRESP != OKAY, record an error and skip the read; go to NEXT. Otherwise go to READ.
- READ: ARVALID until ARREADY, then go to RDATA.
- RDATA: hold RREADY=1. On RVALID, capture RDATA and RRESP; go to CHECK.
- CHECK (1 cycle): an error is RRESP != OKAY or RDATA != expected.
- Error recording: err_count saturates at 511. first_err_index is written on the first error only.
- NEXT: if idx == C_NUM_REGS-1, go to FIN; else idx+1 and go to WRITE.
- FIN: busy=0; done pulses 1 cycle; pass = (err_count==0 && !timeout); return to IDLE.
- Address of register idx = C_BASE_ADDR + idx*C_ADDR_STRIDE, truncated to ADDR width (wraps).
- Pattern(idx), registered and advanced once per NEXT:
  - mode 0: seed + idx, mod 2^32.
  - mode 1: walking one, 1 << (idx mod 32).
  - mode 2: Galois LFSR, polynomial 32'h80200003. Initial value is seed, or 1 if seed==0. One step per register; register 0 uses the unstepped value.
  - mode 3: seed for even idx, ~seed for odd idx.
- Expected read value = pattern written to that register.
- Watchdog: counter reset on entry to each wait state (WRITE, WRESP, READ, RDATA). At C_TIMEOUT cycles, deassert all VALID/READY, set timeout=1, and go to FIN. Registers not yet tested are not counted as errors.
- start while busy is ignored. start coincident with reset deassertion is ignored.
- ARESETN asserted mid-sweep: immediate return to reset values. A partial AXI transaction is abandoned; the slave must also be reset.

Decomposition:
- Shared package axi_lite_test_pkg holds:
  - RESP_OKAY/EXOKAY/SLVERR/DECERR constants;
  - mode encodings MODE_INC, MODE_WALK1, MODE_LFSR, MODE_ALT;
  - the FSM state enum;
  - LFSR_POLY.
- One sub-module, axi_lite_test_patgen: holds mode, seed, load and advance; outputs the current 32-bit pattern.

Test Plan:
- Echo RAM slave, C_NUM_REGS=4, mode 0, seed 32'h0101FFFF -> writes 0101FFFF, 01020000, 01020001, 01020002 at base+0/4/8/C; pass=1, err_count=0, done after 4 write/read pairs.
- Slave with RDATA bit 0 stuck at 0, mode 3, seed 32'hdead0011 -> register 0 mismatches, register 1 (~seed ends in ...EE) matches, register 2 mismatches, register 3 matches; err_count=2, first_err_index=0, pass=0.
- Slave returns SLVERR on B for register 2 only, mode 1 -> no AR issued for index 2; err_count=1, first_err_index=2.
- Slave holds AWREADY low, C_TIMEOUT=16 -> WVALID may complete; after 16 cycles all VALID drop, timeout=1, pass=0, done pulses.
- Randomised ready delays 0..7, with WREADY before AWREADY and vice versa, mode 2, seed 0 -> LFSR starts at 1; pass=1; no VALID drops before its handshake.
- Pulse start mid-sweep (ignored), then drop ARESETN during RDATA -> all outputs return to reset values asynchronously; a new start runs a clean sweep.

Source files
------------

// File: rtl/axi_lite_test_pkg.sv
// Shared constants, FSM state encoding and LFSR helper for the AXI4-Lite
// register self-test master and its pattern generator.
package axi_lite_test_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] MODE_INC   = 2'd0;
  localparam logic [1:0] MODE_WALK1 = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;
  localparam logic [1:0] MODE_ALT   = 2'd3;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WRESP = 3'd2,
    ST_READ  = 3'd3,
    ST_RDATA = 3'd4,
    ST_CHECK = 3'd5,
    ST_NEXT  = 3'd6,
    ST_FIN   = 3'd7
  } state_e;

  // Right-shifting Galois step: feedback taps applied when the bit shifted out is 1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? LFSR_POLY : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/axi_lite_test_patgen.sv
// Test pattern generator: loads mode/seed at sweep start and steps the
// registered pattern once per register.
module axi_lite_test_patgen
  import axi_lite_test_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        advance_i,
  input  logic [1:0]  mode_i,
  input  logic [31:0] seed_i,
  output logic [31:0] pattern_o
);

  logic [1:0]  mode_q, mode_d;
  logic [31:0] seed_q, seed_d;
  logic [31:0] pat_q, pat_d;

  // Next pattern: initial value on load, one step per advance.
  always_comb begin
    mode_d = mode_q;
    seed_d = seed_q;
    pat_d  = pat_q;
    if (load_i) begin
      mode_d = mode_i;
      seed_d = seed_i;
      case (mode_i)
        MODE_WALK1: pat_d = 32'h0000_0001;
        MODE_LFSR:  pat_d = (seed_i == 32'h0000_0000) ? 32'h0000_0001 : seed_i;
        default:    pat_d = seed_i;
      endcase
    end else if (advance_i) begin
      case (mode_q)
        MODE_INC:   pat_d = pat_q + 32'd1;
        MODE_WALK1: pat_d = {pat_q[30:0], pat_q[31]};
        MODE_LFSR:  pat_d = lfsr_step(pat_q);
        MODE_ALT:   pat_d = (pat_q == seed_q) ? ~seed_q : seed_q;
        default:    pat_d = pat_q;
      endcase
    end else begin
      pat_d = pat_q;
    end
  end

  // Pattern state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q <= 2'd0;
      seed_q <= 32'h0000_0000;
      pat_q  <= 32'h0000_0000;
    end else begin
      mode_q <= mode_d;
      seed_q <= seed_d;
      pat_q  <= pat_d;
    end
  end

  assign pattern_o = pat_q;

endmodule

// File: rtl/axi_lite_reg_test_master.sv
// AXI4-Lite master running a write/read-back sweep over a window of slave
// registers, counting mismatches and error responses, with a handshake watchdog.
module axi_lite_reg_test_master
  import axi_lite_test_pkg::*;
#(
  parameter int          C_M_AXI_DATA_WIDTH = 32,
  parameter int          C_M_AXI_ADDR_WIDTH = 32,
  parameter logic [31:0] C_BASE_ADDR        = 32'h0000_0000,
  parameter int          C_NUM_REGS         = 4,
  parameter int          C_ADDR_STRIDE      = 4,
  parameter int          C_TIMEOUT          = 1024
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            start,
  input  logic [1:0]                      mode,
  input  logic [31:0]                     seed,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic                            timeout,
  output logic [8:0]                      err_count,
  output logic [7:0]                      first_err_index,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int WDT_W = $clog2(C_TIMEOUT + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(C_TIMEOUT - 1);
  localparam logic [7:0] IDX_LAST = 8'(C_NUM_REGS - 1);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BASE = C_M_AXI_ADDR_WIDTH'(C_BASE_ADDR);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] STRIDE = C_M_AXI_ADDR_WIDTH'(C_ADDR_STRIDE);

  state_e                          state_q, state_d;
  logic [7:0]                      idx_q, idx_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WDT_W-1:0]                wdt_q, wdt_d;
  logic                            awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                            bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic                            busy_q, busy_d, done_q, done_d;
  logic                            pass_q, pass_d, timeout_q, timeout_d;
  logic [8:0]                      err_count_q, err_count_d;
  logic [7:0]                      first_err_q, first_err_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]                      rresp_q, rresp_d;
  logic                            armed_q;
  logic                            err_s, to_s, load_s, advance_s, aw_pend_s, w_pend_s;
  logic [31:0]                     pattern_s;

  // The first edge after reset release never accepts start.
  assign load_s    = (state_q == ST_IDLE) && start && armed_q;
  assign advance_s = (state_q == ST_NEXT) && (idx_q != IDX_LAST);
  assign aw_pend_s = awvalid_q & ~M_AXI_AWREADY;
  assign w_pend_s  = wvalid_q & ~M_AXI_WREADY;

  axi_lite_test_patgen u_patgen (
    .clk_i     (ACLK),
    .rst_ni    (ARESETN),
    .load_i    (load_s),
    .advance_i (advance_s),
    .mode_i    (mode),
    .seed_i    (seed),
    .pattern_o (pattern_s)
  );

  // Sweep sequencer: next state, channel handshakes, error and watchdog bookkeeping.
  always_comb begin
    state_d = state_q;  idx_d = idx_q;  addr_d = addr_q;  wdt_d = wdt_q;
    awvalid_d = awvalid_q;  wvalid_d = wvalid_q;  bready_d = bready_q;
    arvalid_d = arvalid_q;  rready_d = rready_q;
    busy_d = busy_q;  done_d = 1'b0;  pass_d = pass_q;  timeout_d = timeout_q;
    err_count_d = err_count_q;  first_err_d = first_err_q;
    rdata_d = rdata_q;  rresp_d = rresp_q;
    err_s = 1'b0;  to_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_s) begin
          state_d = ST_WRITE;  busy_d = 1'b1;  idx_d = 8'd0;  addr_d = BASE;
          err_count_d = 9'd0;  first_err_d = 8'd0;  pass_d = 1'b0;  timeout_d = 1'b0;
          awvalid_d = 1'b1;  wvalid_d = 1'b1;  wdt_d = WDT_W'(0);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        awvalid_d = aw_pend_s;
        wvalid_d  = w_pend_s;
        if (!aw_pend_s && !w_pend_s) begin
          state_d = ST_WRESP;  bready_d = 1'b1;  wdt_d = WDT_W'(0);
        end else if (wdt_q == WDT_LAST) begin
          to_s = 1'b1;
        end else begin
          wdt_d = wdt_q + WDT_W'(1);
        end
      end
      ST_WRESP: begin
        if (M_AXI_BVALID) begin
          bready_d = 1'b0;  wdt_d = WDT_W'(0);
          if (M_AXI_BRESP != RESP_OKAY) begin
            err_s = 1'b1;  state_d = ST_NEXT;
          end else begin
            arvalid_d = 1'b1;  state_d = ST_READ;
          end
        end else if (wdt_q == WDT_LAST) begin
          to_s = 1'b1;
        end else begin
          wdt_d = wdt_q + WDT_W'(1);
        end
      end
      ST_READ: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;  rready_d = 1'b1;  wdt_d = WDT_W'(0);  state_d = ST_RDATA;
        end else if (wdt_q == WDT_LAST) begin
          to_s = 1'b1;
        end else begin
          wdt_d = wdt_q + WDT_W'(1);
        end
      end
      ST_RDATA: begin
        if (M_AXI_RVALID) begin
          rready_d = 1'b0;  rdata_d = M_AXI_RDATA;  rresp_d = M_AXI_RRESP;  state_d = ST_CHECK;
        end else if (wdt_q == WDT_LAST) begin
          to_s = 1'b1;
        end else begin
          wdt_d = wdt_q + WDT_W'(1);
        end
      end
      ST_CHECK: begin
        err_s   = (rresp_q != RESP_OKAY) || (rdata_q != pattern_s);
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (idx_q == IDX_LAST) begin
          state_d = ST_FIN;
        end else begin
          idx_d = idx_q + 8'd1;  addr_d = addr_q + STRIDE;
          awvalid_d = 1'b1;  wvalid_d = 1'b1;  wdt_d = WDT_W'(0);  state_d = ST_WRITE;
        end
      end
      ST_FIN: begin
        busy_d = 1'b0;  done_d = 1'b1;
        pass_d = (err_count_q == 9'd0) && !timeout_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // err_count saturates; first_err_index latches only the first failing register.
    if (err_s) begin
      err_count_d = (err_count_q == 9'h1FF) ? err_count_q : err_count_q + 9'd1;
      first_err_d = (err_count_q == 9'd0) ? idx_q : first_err_q;
    end else begin
      err_count_d = err_count_d;
    end

    if (to_s) begin
      awvalid_d = 1'b0;  wvalid_d = 1'b0;  bready_d = 1'b0;
      arvalid_d = 1'b0;  rready_d = 1'b0;
      timeout_d = 1'b1;  state_d = ST_FIN;
    end else begin
      timeout_d = timeout_d;
    end
  end

  // Sequencer and output registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= ST_IDLE;  idx_q <= 8'd0;  addr_q <= '0;  wdt_q <= '0;
      awvalid_q <= 1'b0;  wvalid_q <= 1'b0;  bready_q <= 1'b0;
      arvalid_q <= 1'b0;  rready_q <= 1'b0;
      busy_q <= 1'b0;  done_q <= 1'b0;  pass_q <= 1'b0;  timeout_q <= 1'b0;
      err_count_q <= 9'd0;  first_err_q <= 8'd0;
      rdata_q <= '0;  rresp_q <= 2'b00;  armed_q <= 1'b0;
    end else begin
      state_q <= state_d;  idx_q <= idx_d;  addr_q <= addr_d;  wdt_q <= wdt_d;
      awvalid_q <= awvalid_d;  wvalid_q <= wvalid_d;  bready_q <= bready_d;
      arvalid_q <= arvalid_d;  rready_q <= rready_d;
      busy_q <= busy_d;  done_q <= done_d;  pass_q <= pass_d;  timeout_q <= timeout_d;
      err_count_q <= err_count_d;  first_err_q <= first_err_d;
      rdata_q <= rdata_d;  rresp_q <= rresp_d;  armed_q <= 1'b1;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign timeout         = timeout_q;
  assign err_count       = err_count_q;
  assign first_err_index = first_err_q;
  assign M_AXI_AWADDR    = addr_q;
  assign M_AXI_AWPROT    = 3'b000;
  assign M_AXI_AWVALID   = awvalid_q;
  assign M_AXI_WDATA     = pattern_s;
  assign M_AXI_WSTRB     = {(C_M_AXI_DATA_WIDTH/8){1'b1}};
  assign M_AXI_WVALID    = wvalid_q;
  assign M_AXI_BREADY    = bready_q;
  assign M_AXI_ARADDR    = addr_q;
  assign M_AXI_ARPROT    = 3'b000;
  assign M_AXI_ARVALID   = arvalid_q;
  assign M_AXI_RREADY    = rready_q;

endmodule

// File: tb/tb_axi_lite_reg_test_master.sv
// Scoreboard bench: a reference model predicts every AXI address/data beat and
// the sweep result; a monitor compares them as the DUT presents handshakes.
module tb_axi_lite_reg_test_master;

  localparam logic [31:0] BASE   = 32'hFFFF_FFF0;
  localparam int          NREGS  = 6;
  localparam int          TMO    = 16;
  localparam logic [31:0] POLY   = 32'h8020_0003;

  logic        ACLK, ARESETN, start;
  logic [1:0]  mode;
  logic [31:0] seed;
  logic        busy, done, pass, timeout;
  logic [8:0]  err_count;
  logic [7:0]  first_err_index;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  axi_lite_reg_test_master #(
    .C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(32), .C_BASE_ADDR(BASE),
    .C_NUM_REGS(NREGS), .C_ADDR_STRIDE(4), .C_TIMEOUT(TMO)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .mode(mode), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .first_err_index(first_err_index),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_aw[$];
  logic [31:0] exp_w[$];
  logic [31:0] exp_ar[$];
  logic [18:0] exp_res[$];   // {pass, timeout, err_count, first_err_index}

  // slave behaviour knobs and state
  bit          hold_aw, stuck0;
  int          slverr_idx;
  bit          aw_hs, aw_got, w_hs, w_got, b_hs, ar_hs, ar_got, r_hs;
  int          aw_dly, w_dly, ar_dly;
  logic [31:0] aw_addr, w_data, ar_addr;
  logic [31:0] mem [logic [31:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: event with no expected entry", name);
  endtask

  function automatic logic [31:0] model_pat(input logic [1:0] m, input logic [31:0] s, input int i);
    logic [31:0] x;
    case (m)
      2'd0: return s + 32'(i);
      2'd1: return 32'h1 << (i % 32);
      2'd2: begin
        x = (s == 32'h0) ? 32'h1 : s;
        for (int k = 0; k < i; k++) x = (x >> 1) ^ (x[0] ? POLY : 32'h0);
        return x;
      end
      default: return (i % 2 == 1) ? ~s : s;
    endcase
  endfunction

  task automatic slave_clear();
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
    M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RDATA = 32'h0; M_AXI_RRESP = 2'b00;
    aw_hs = 0; aw_got = 0; w_hs = 0; w_got = 0; b_hs = 0; ar_hs = 0; ar_got = 0; r_hs = 0;
    aw_dly = $urandom_range(7, 0); w_dly = $urandom_range(7, 0); ar_dly = $urandom_range(7, 0);
  endtask

  // Echo-RAM slave with random ready delays and optional faults; acts on the falling edge.
  initial begin
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        slave_clear();
      end else begin
        if (aw_hs) begin
          M_AXI_AWREADY = 1'b0; aw_hs = 0; aw_got = 1; aw_dly = $urandom_range(7, 0);
        end else if (M_AXI_AWVALID && !aw_got && !hold_aw) begin
          if (aw_dly == 0) M_AXI_AWREADY = 1'b1; else aw_dly--;
        end
        aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
        if (aw_hs) aw_addr = M_AXI_AWADDR;

        if (w_hs) begin
          M_AXI_WREADY = 1'b0; w_hs = 0; w_got = 1; w_dly = $urandom_range(7, 0);
        end else if (M_AXI_WVALID && !w_got) begin
          if (w_dly == 0) M_AXI_WREADY = 1'b1; else w_dly--;
        end
        w_hs = M_AXI_WVALID && M_AXI_WREADY;
        if (w_hs) w_data = M_AXI_WDATA;

        if (b_hs) begin
          M_AXI_BVALID = 1'b0; b_hs = 0;
        end else if (aw_got && w_got && !M_AXI_BVALID) begin
          mem[aw_addr] = w_data;
          M_AXI_BRESP  = (((aw_addr - BASE) >> 2) == 32'(slverr_idx)) ? 2'b10 : 2'b00;
          M_AXI_BVALID = 1'b1; aw_got = 0; w_got = 0;
        end
        b_hs = M_AXI_BVALID && M_AXI_BREADY;

        if (ar_hs) begin
          M_AXI_ARREADY = 1'b0; ar_hs = 0; ar_got = 1; ar_dly = $urandom_range(7, 0);
        end else if (M_AXI_ARVALID && !ar_got) begin
          if (ar_dly == 0) M_AXI_ARREADY = 1'b1; else ar_dly--;
        end
        ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
        if (ar_hs) ar_addr = M_AXI_ARADDR;

        if (r_hs) begin
          M_AXI_RVALID = 1'b0; r_hs = 0;
        end else if (ar_got && !M_AXI_RVALID) begin
          M_AXI_RDATA = mem.exists(ar_addr) ? mem[ar_addr] : 32'h0;
          if (stuck0) M_AXI_RDATA[0] = 1'b0;
          M_AXI_RRESP = 2'b00; M_AXI_RVALID = 1'b1; ar_got = 0;
        end
        r_hs = M_AXI_RVALID && M_AXI_RREADY;
      end
    end
  end

  // Monitor: pops the scoreboard whenever a beat or a done pulse is presented.
  initial begin
    bit pend_aw, pend_w, pend_ar;
    pend_aw = 0; pend_w = 0; pend_ar = 0;
    forever begin
      @(negedge ACLK);
      #1;
      if (!ARESETN) begin
        pend_aw = 0; pend_w = 0; pend_ar = 0;
      end else begin
        if (pend_aw) chk("awvalid_held", M_AXI_AWVALID | timeout, 1);
        if (pend_w)  chk("wvalid_held",  M_AXI_WVALID  | timeout, 1);
        if (pend_ar) chk("arvalid_held", M_AXI_ARVALID | timeout, 1);
        if (M_AXI_AWVALID && M_AXI_AWREADY) begin
          if (exp_aw.size() == 0) note_fail("aw_extra");
          else chk("awaddr", M_AXI_AWADDR, exp_aw.pop_front());
        end
        if (M_AXI_WVALID && M_AXI_WREADY) begin
          if (exp_w.size() == 0) note_fail("w_extra");
          else chk("wdata", M_AXI_WDATA, exp_w.pop_front());
        end
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
          if (exp_ar.size() == 0) note_fail("ar_extra");
          else chk("araddr", M_AXI_ARADDR, exp_ar.pop_front());
        end
        if (done) begin
          chk("busy_at_done", busy, 0);
          if (exp_res.size() == 0) note_fail("done_extra");
          else chk("result{pass,tmo,err,first}", {pass, timeout, err_count, first_err_index},
                   exp_res.pop_front());
        end
        pend_aw = M_AXI_AWVALID && !M_AXI_AWREADY;
        pend_w  = M_AXI_WVALID  && !M_AXI_WREADY;
        pend_ar = M_AXI_ARVALID && !M_AXI_ARREADY;
      end
    end
  end

  task automatic predict(input logic [1:0] m, input logic [31:0] s);
    int errs, first;
    logic [31:0] a, p, rb;
    errs = 0; first = 0;
    for (int i = 0; i < NREGS; i++) begin
      a = BASE + 32'(i) * 32'd4;
      p = model_pat(m, s, i);
      exp_w.push_back(p);
      if (hold_aw) break;
      exp_aw.push_back(a);
      if (i == slverr_idx) begin
        if (errs == 0) first = i;
        errs++;
      end else begin
        exp_ar.push_back(a);
        rb = stuck0 ? (p & 32'hFFFF_FFFE) : p;
        if (rb != p) begin
          if (errs == 0) first = i;
          errs++;
        end
      end
    end
    if (hold_aw) exp_res.push_back({1'b0, 1'b1, 9'd0, 8'd0});
    else exp_res.push_back({(errs == 0), 1'b0, 9'(errs), 8'(first)});
  endtask

  task automatic flush();
    exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_res.delete();
  endtask

  task automatic run_sweep(input logic [1:0] m, input logic [31:0] s, input bit hold,
                           input bit stk, input int serr);
    int cyc;
    @(posedge ACLK); #2;
    hold_aw = hold; stuck0 = stk; slverr_idx = serr;
    slave_clear();
    predict(m, s);
    @(negedge ACLK); mode = m; seed = s; start = 1'b1;
    @(negedge ACLK); start = 1'b0; mode = 2'($urandom); seed = $urandom;
    for (cyc = 0; cyc < 3000 && exp_res.size() != 0; cyc++) @(negedge ACLK);
    if (exp_res.size() != 0) $display("FAIL done_wait: no done within %0d cycles", cyc);
    if (exp_res.size() != 0) bad++;
    total++;
    repeat (3) @(negedge ACLK);
    chk("aw_left", exp_aw.size(), 0);
    chk("w_left", exp_w.size(), 0);
    chk("ar_left", exp_ar.size(), 0);
    chk("busy_idle", busy, 0);
    if (hold) chk("valids_after_timeout", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 0);
    flush();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_valids"}, {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
    chk({tag, "_status"}, {busy, done, pass, timeout}, 0);
    chk({tag, "_errs"}, {err_count, first_err_index}, 0);
    chk({tag, "_addr_data"}, {M_AXI_AWADDR, M_AXI_WDATA}, 0);
  endtask

  initial begin
    int cyc;
    ARESETN = 1'b0; start = 1'b0; mode = 2'd0; seed = 32'h0;
    hold_aw = 0; stuck0 = 0; slverr_idx = -1;
    slave_clear();
    repeat (3) @(negedge ACLK);
    #1;
    chk_reset_values("reset");
    chk("prot_strb", {M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WSTRB}, {3'b000, 3'b000, 4'hF});

    // start high on the first edge after reset release must be ignored
    start = 1'b1;
    @(negedge ACLK); ARESETN = 1'b1;
    @(negedge ACLK); start = 1'b0;
    repeat (3) @(negedge ACLK);
    chk("start_at_reset_release", busy, 0);

    run_sweep(2'd0, 32'h0101_FFFF, 0, 0, -1);
    run_sweep(2'd3, 32'hDEAD_0011, 0, 1, -1);
    run_sweep(2'd1, 32'h1234_5678, 0, 0, 2);
    run_sweep(2'd0, 32'hCAFE_0000, 1, 0, -1);
    run_sweep(2'd2, 32'h0000_0000, 0, 0, -1);
    for (int t = 0; t < 6; t++)
      run_sweep(2'($urandom_range(3, 0)), $urandom, 0, bit'($urandom_range(1, 0)),
                ($urandom_range(3, 0) == 0) ? int'($urandom_range(NREGS - 1, 0)) : -1);

    // mid-sweep: stray start is ignored, then reset lands while in RDATA
    @(posedge ACLK); #2;
    hold_aw = 0; stuck0 = 0; slverr_idx = -1;
    slave_clear();
    predict(2'd2, 32'h0BAD_F00D);
    @(negedge ACLK); mode = 2'd2; seed = 32'h0BAD_F00D; start = 1'b1;
    @(negedge ACLK); start = 1'b0;
    repeat (3) @(negedge ACLK);
    mode = 2'd0; seed = 32'h0; start = 1'b1;
    @(negedge ACLK); start = 1'b0;
    chk("busy_mid_sweep", busy, 1);
    for (cyc = 0; cyc < 200 && !M_AXI_RREADY; cyc++) @(negedge ACLK);
    chk("reached_rdata", M_AXI_RREADY, 1);
    @(posedge ACLK); #3;
    ARESETN = 1'b0;
    #1;
    chk_reset_values("async_reset");
    flush();
    repeat (2) @(negedge ACLK);
    @(posedge ACLK); #3;
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);
    run_sweep(2'd1, 32'h0, 0, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
